cond_unit: RTL

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - ARM-style conditional execution unit with flag register and annulled-instruction counter
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   current instruction valid and not stalled
//   Cond       in   [3:0] condition field of the current instruction
//   ALUFlags   in   [3:0] {N,Z,C,V} produced by the ALU for the current instruction
//   FlagW      in   [1:0] bit1 requests N,Z update; bit0 requests C,V update
//   PCS        in   decoder PC-write request
//   RegW       in   decoder register-write request
//   MemW       in   decoder memory-write request
//   NoWrite    in   compare-type instruction, register write suppressed
//   cnt_clr    in   synchronous clear of the annulled counter
//   PCSrc      out  gated PC write enable
//   RegWrite   out  gated register write enable
//   MemWrite   out  gated memory write enable
//   CondEx     out  condition passed (from registered flags)
//   Flags      out  [3:0] registered {N,Z,C,V}
//   annul_cnt  out  [CNT_W-1:0] saturating count of annulled instructions
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             cnt_clr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] annul_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic flag_n, flag_z, flag_c, flag_v;
    logic executes;
    logic annulled;
    logic nz_we;
    logic cv_we;

    assign flag_n = Flags[3];
    assign flag_z = Flags[2];
    assign flag_c = Flags[1];
    assign flag_v = Flags[0];

    // Condition is judged only against the registered flags, so a flag
    // update from this instruction is visible to the next one at the earliest.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = flag_z;
            4'b0001: CondEx = ~flag_z;
            4'b0010: CondEx = flag_c;
            4'b0011: CondEx = ~flag_c;
            4'b0100: CondEx = flag_n;
            4'b0101: CondEx = ~flag_n;
            4'b0110: CondEx = flag_v;
            4'b0111: CondEx = ~flag_v;
            4'b1000: CondEx = flag_c & ~flag_z;
            4'b1001: CondEx = ~flag_c | flag_z;
            4'b1010: CondEx = (flag_n == flag_v);
            4'b1011: CondEx = (flag_n != flag_v);
            4'b1100: CondEx = ~flag_z & (flag_n == flag_v);
            4'b1101: CondEx = flag_z | (flag_n != flag_v);
            default: CondEx = 1'b1;
        endcase
    end

    assign executes = en & CondEx;
    assign annulled = en & ~CondEx;
    assign nz_we    = executes & FlagW[1];
    assign cv_we    = executes & FlagW[0];

    // Reset is folded into the enables so nothing escapes while it is held.
    assign PCSrc    = executes & PCS & ~reset;
    assign RegWrite = executes & RegW & ~NoWrite & ~reset;
    assign MemWrite = executes & MemW & ~reset;

    // The two flag groups have independent write enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else begin
            if (nz_we) begin
                Flags[3:2] <= ALUFlags[3:2];
            end
            if (cv_we) begin
                Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            annul_cnt <= '0;
        end else if (cnt_clr) begin
            annul_cnt <= '0;
        end else if (annulled && (annul_cnt != CNT_MAX)) begin
            annul_cnt <= annul_cnt + CNT_ONE;
        end
    end

endmodule
